// File: rtl/mem_access_unit.sv
// MEM-stage initiator mapping lb/lbu/lh/lhu/lw/sb/sh/sw onto a word-only data memory;
// sub-word stores use a read-modify-write. Optional misalignment trapping: MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h400,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(MEM_BYTES) - 32'd1;
  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [1:0]  SZ_RSVD   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE} state_t;

  state_t      r_state, w_next_state;
  logic        r_write, r_signed, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_merged;
  logic        r_resp_valid, r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_misalign, w_req_err, w_accept, w_subword_store;
  logic        w_mem_read, w_mem_write;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data, w_merged;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Full 32-bit compare: addresses near 0xFFFFFFFF must not wrap into the window.
  assign w_req_err = (req_addr < BASE_ADDR) || (req_addr > LAST_ADDR) ||
                     (req_size == SZ_RSVD) || w_misalign;
  assign w_accept        = (r_state == S_IDLE) && req_valid;
  assign w_subword_store = r_write && (r_size != SZ_WORD);

  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = mem_rdata;
    if (r_size == SZ_BYTE)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else if (r_addr[1])
      w_merged[31:16] = r_wdata[15:0];
    else
      w_merged[15:0] = r_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
    w_next_state = r_state;
    req_ready    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next_state = S_ACCESS;
      end
      S_ACCESS: begin
        mem_addr     = {r_addr[31:2], 2'b00};
        w_next_state = S_IDLE;
        if (!r_err) begin
          if (!r_write) begin
            w_mem_read = 1'b1;
          end else if (!w_subword_store) begin
            w_mem_write = 1'b1;
            mem_wdata   = r_wdata;
          end else begin
            w_mem_read   = 1'b1;
            w_next_state = S_MERGE;
          end
        end
      end
      S_MERGE: begin
        mem_addr     = {r_addr[31:2], 2'b00};
        w_mem_write  = 1'b1;
        mem_wdata    = r_merged;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Strobes are masked in a reset cycle so an aborted MERGE never commits.
  assign mem_read  = w_mem_read  && !reset;
  assign mem_write = w_mem_write && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_err        <= 1'b0;
      r_merged     <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == S_ACCESS) begin
        if (!r_err && w_subword_store) begin
          r_merged <= w_merged;
        end else begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= r_err;
          r_resp_rdata <= (r_err || r_write) ? 32'd0 : w_load_data;
        end
      end
      if (r_state == S_MERGE) r_resp_valid <= 1'b1;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, randomized and directed
// requests, monitor comparing every response, strobe counts, latency and final memory image.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam logic [31:0] BASE = 32'h400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.BASE_ADDR(32'h400), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory the DUT talks to: combinational read, write on posedge.
  logic [31:0] mem_words [0:255];
  assign mem_rdata = mem_words[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem_words[mem_addr[9:2]] <= mem_wdata;

  // Reference view of the same memory, one byte per entry.
  logic [7:0] ref_mem [0:1023];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          accept;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
  endfunction

  // Behavioural model: applies the access to ref_mem and returns the expected response.
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          n;
    int          base;
    logic [31:0] v;
    e.rdata  = 32'd0;
    e.lat    = 2;
    e.accept = 0;
    e.nrd    = 0;
    e.nwr    = 0;
    e.waddr  = addr & ~32'h3;
    e.err    = (addr < BASE) || (addr > BASE + 32'd1023) || (sz == 2'd3);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1 && addr[0]) e.err = 1'b1;
    if (sz == 2'd2 && addr[1:0] != 2'd0) e.err = 1'b1;
`endif
    if (e.err) return e;
    n    = 1 << sz;
    base = int'(addr - BASE) & ~(n - 1);
    if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
      e.nwr = 1;
      e.nrd = (n < 4) ? 1 : 0;
      e.lat = (n < 4) ? 3 : 2;
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
      if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      e.rdata = v;
      e.nrd   = 1;
    end
    return e;
  endfunction

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    e          = model(wr, sz, sgn, addr, wd);
    e.accept   = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: counts strobes and stall cycles, compares each response with the scoreboard head.
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_low = 0;
  logic        both_seen = 1'b0;
  logic [31:0] last_addr = 32'd0;
  exp_t        m_e;

  always @(negedge clk) begin
    if (reset) begin
      n_rd = 0; n_wr = 0; n_low = 0; both_seen = 1'b0;
    end else begin
      if (mem_read)  begin n_rd++; last_addr = mem_addr; end
      if (mem_write) begin n_wr++; last_addr = mem_addr; end
      if (mem_read && mem_write) both_seen = 1'b1;
      if (!req_ready) n_low++;
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          m_e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, m_e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, m_e.err});
          check("latency", cyc - m_e.accept, m_e.lat);
          check("read_strobes", n_rd, m_e.nrd);
          check("write_strobes", n_wr, m_e.nwr);
          check("ready_low_cycles", n_low, m_e.lat - 1);
          check("rd_wr_exclusive", {31'd0, both_seen}, 32'd0);
          if (m_e.nrd + m_e.nwr > 0) check("mem_addr", last_addr, m_e.waddr);
        end
        n_rd = 0; n_wr = 0; n_low = 0; both_seen = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    logic [1:0]  s;
    int          r;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem_words[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
    end

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h404, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h406, 32'h000000AA);
    issue(1'b0, 2'd2, 1'b0, 32'h404, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h408, 32'h8000F0FF);
    issue(1'b0, 2'd0, 1'b1, 32'h408, 32'd0);
    issue(1'b0, 2'd0, 1'b0, 32'h408, 32'd0);
    issue(1'b0, 2'd1, 1'b1, 32'h40A, 32'd0);
    issue(1'b0, 2'd1, 1'b0, 32'h40A, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);
    issue(1'b1, 2'd2, 1'b0, 32'h800, 32'h12345678);
    issue(1'b0, 2'd3, 1'b0, 32'h410, 32'd0);
    issue(1'b0, 2'd1, 1'b1, 32'h401, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'd0);
    drain();
    check("word_400", mem_words[0], 32'hDEADBEEF);
    check("word_404_merged", mem_words[1], 32'h11AA3344);
    check("word_408", mem_words[2], 32'h8000F0FF);

    // Sub-word store aborted by reset while in MERGE.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h40C; req_wdata = 32'h00005A5A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("merge_write_strobe", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("merge_write_gated", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {31'd0, req_ready}, 32'd1);
    check("post_reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("word_40C_unchanged", mem_words[3], ref_word(3));

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h3F0 + $urandom_range(0, 15);
      else if (r == 2) a = 32'h7F0 + $urandom_range(0, 31);
      else if (r < 6)  a = 32'h400 + $urandom_range(0, 31);
      else             a = 32'h400 + $urandom_range(0, 1023);
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    drain();

    for (int i = 0; i < 256; i++) check("final_mem_word", mem_words[i], ref_word(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
